// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for the bit-serial adder controller.
//
// Signals:
//   start     request strobe (requester -> controller)
//   a, b      WIDTH-bit operands, captured on the accepted start edge
//   cin       carry-in, captured on the accepted start edge
//   busy      high while an addition is being shifted through
//   done      one-cycle pulse when the result registers update
//   sum       registered result, held until the next completion
//   cout      carry out of bit WIDTH-1
//   overflow  signed overflow of the completed addition
//
// Handshake: start is a level sampled on every rising edge, but only when the
// controller is idle or in its done cycle; a sampled start=1 there accepts
// a/b/cin on that same edge. While busy=1 start is ignored. done is high for
// exactly one cycle and sum/cout/overflow are valid from that cycle onward.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial addition controller: adds two WIDTH-bit operands one bit per
// clock, LSB first, through a single one-bit full adder.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears all state and outputs
//   bus        serial_adder_ctrl_if slave side (start/a/b/cin in,
//              busy/done/sum/cout/overflow out)
//   state_dbg  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Timing: with start accepted at edge E0, busy is high for the WIDTH cycles
// after E0 and done is high in cycle WIDTH+1. A start seen during the done
// cycle is accepted immediately, so one addition completes per WIDTH+1 cycles.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  serial_adder_ctrl_if.slave bus,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 sum bits produced so far; the final bit goes straight
  // into the result register on the last step.
  logic [WIDTH-2:0] sum_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             overflow_q;

  logic             accept;
  logic             last_bit;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_nxt;

  // One-bit full adder on the current LSBs and the running carry.
  assign fa_s = a_sh[0] ^ b_sh[0] ^ carry_q;
  assign fa_c = (a_sh[0] & b_sh[0]) | (carry_q & (a_sh[0] ^ b_sh[0]));

  assign sum_nxt  = {fa_s, sum_sh};
  assign last_bit = (cnt == LAST);
  assign accept   = bus.start && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh       <= '0;
      b_sh       <= '0;
      sum_sh     <= '0;
      carry_q    <= 1'b0;
      cnt        <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      a_sh    <= bus.a;
      b_sh    <= bus.b;
      carry_q <= bus.cin;
      cnt     <= '0;
    end else if (state == RUN) begin
      sum_sh  <= sum_nxt[WIDTH-1:1];
      carry_q <= fa_c;
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      if (last_bit) begin
        // At the MSB step carry_q is the carry into the MSB, so signed
        // overflow is that carry XOR the carry out.
        sum_q      <= sum_nxt;
        cout_q     <= fa_c;
        overflow_q <= carry_q ^ fa_c;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;

  serial_adder_ctrl_if #(.WIDTH(W)) bif ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #100 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // scoreboard: {overflow, cout, sum}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] outs();
    return {bif.overflow, bif.cout, bif.sum};
  endfunction

  // One addition with hand-computed expectation. inj_cyc>0 pulses a start with
  // other operands in that RUN cycle, which must be ignored.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf,
                        input int inj_cyc);
    int busy_n;
    int done_n;
    int done_at;
    busy_n  = 0;
    done_n  = 0;
    done_at = 0;
    @(negedge clk);
    bif.start = 1'b1;
    bif.a     = ta;
    bif.b     = tb_v;
    bif.cin   = tc;
    exp_q.push_back({e_ovf, e_cout, e_sum});
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bif.start = 1'b0;
        bif.a     = W'($urandom_range(0, 255));
        bif.b     = W'($urandom_range(0, 255));
        bif.cin   = 1'($urandom_range(0, 1));
      end
      if (n == inj_cyc) begin
        bif.start = 1'b1;
        bif.a     = 8'hAA;
        bif.b     = 8'h55;
        bif.cin   = 1'b1;
      end else if (n == inj_cyc + 1) begin
        bif.start = 1'b0;
      end
      if (bif.busy) busy_n++;
      if (bif.done) begin
        done_n++;
        done_at = n;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          last_res = exp_q.pop_front();
          check("result", 32'(outs()), 32'(last_res));
        end
      end else begin
        check("hold", 32'(outs()), 32'(last_res));
      end
    end
    check("done_count", done_n, 1);
    check("done_latency", done_at, W + 1);
    check("busy_cycles", busy_n, W);
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    bif.start = 1'b1;
    bif.a     = 8'h12;
    bif.b     = 8'h34;
    bif.cin   = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) bif.start = 1'b0;
      if (n == 4) reset = 1'b1;
      if (n == 5) begin
        reset = 1'b0;
        check("rst_busy", bif.busy, 1'b0);
        check("rst_outs", 32'(outs()), 32'd0);
        check("rst_state", state_dbg, 2'd0);
      end
      if (n > 5) check("rst_idle_busy", bif.busy, 1'b0);
      check("rst_no_done", bif.done, 1'b0);
    end
    last_res = '0;
  endtask

  task automatic continuous();
    int prev;
    int done_n;
    prev   = 0;
    done_n = 0;
    @(negedge clk);
    bif.start = 1'b1;
    bif.a     = 8'h01;
    bif.b     = 8'h01;
    bif.cin   = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      check("cont_busy", bif.busy, !bif.done);
      if (bif.done) begin
        done_n++;
        check("cont_sum", 32'(outs()), 32'h002);
        check("cont_period", n - prev, W + 1);
        prev = n;
      end
    end
    check("cont_done_count", done_n, 3);
    bif.start = 1'b0;
    repeat (12) @(negedge clk);
    last_res = 10'h002;
  endtask

  initial begin
    reset     = 1'b1;
    bif.start = 1'b0;
    bif.a     = '0;
    bif.b     = '0;
    bif.cin   = 1'b0;
    last_res  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", bif.busy, 1'b0);
    check("reset_done", bif.done, 1'b0);
    check("reset_outs", 32'(outs()), 32'd0);
    check("reset_state", state_dbg, 2'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_state", state_dbg, 2'd0);

    run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_op(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 0);
    // -128 + -128: carry out, signed overflow
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    // 0xC3 + 0x3C + 1 = 0x100
    run_op(8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    // start during RUN cycle 3 is ignored
    run_op(8'h21, 8'h42, 1'b0, 8'h63, 1'b0, 1'b0, 3);

    reset_mid_run();
    run_op(8'h10, 8'h0F, 1'b1, 8'h20, 1'b0, 1'b0, 0);

    continuous();

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
